// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: FSM encoding,
// BCD digit limits and the preset clamp helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic [3:0] clamp_digit(input logic [3:0] value,
                                             input logic [3:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with synchronous load and a borrow chain.
// The digit steps only when the tick enable and the lower digit's borrow coincide.
module bcd_down_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_en,
  input  logic       borrow_in,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic step;

  assign step       = dec_en & borrow_in;
  assign borrow_out = step & (digit == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (step) begin
      digit <= (digit == 4'd0) ? 4'(MAX) : digit - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer_p.sv
// Parametrised MM:SS countdown timer: FSM, tick prescaler, alarm stretcher
// and preset clamping around a four-digit BCD borrow chain.
module countdown_timer_p
  import timer_pkg::*;
#(
  parameter int TICK_DIV     = 100_000_000,
  parameter int ALARM_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       auto_reload,
  input  logic [3:0] m_t,
  input  logic [3:0] m_o,
  input  logic [3:0] s_t,
  input  logic [3:0] s_o,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       alarm,
  output logic       err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYCLES);

  state_t          state, state_next;
  logic [PW-1:0]   presc;
  logic [AW-1:0]   alarm_cnt, alarm_cnt_next;
  logic [3:0]      pre_mt, pre_mo, pre_st, pre_so;
  logic [3:0]      cl_mt, cl_mo, cl_st, cl_so;
  logic [3:0]      ld_mt, ld_mo, ld_st, ld_so;
  logic            clamped;
  logic            tick;
  logic            count_zero;
  logic            reach_zero;
  logic            reload;
  logic            digit_load;
  logic            b_so, b_st, b_mo, b_mt;

  assign cl_mt = clamp_digit(m_t, DIGIT_MAX);
  assign cl_mo = clamp_digit(m_o, DIGIT_MAX);
  assign cl_st = clamp_digit(s_t, SEC_TENS_MAX);
  assign cl_so = clamp_digit(s_o, DIGIT_MAX);

  assign clamped = (m_t > DIGIT_MAX) | (m_o > DIGIT_MAX) |
                   (s_t > SEC_TENS_MAX) | (s_o > DIGIT_MAX);

  assign tick       = (state == RUN) && (presc == PRESC_LAST);
  assign count_zero = ({d3, d2, d1, d0} == 16'h0000);
  // The only way to land on 00:00 is a tick taken while showing 00:01.
  assign reach_zero = tick && ({d3, d2, d1, d0} == 16'h0001) && !load;
  assign reload     = reach_zero && auto_reload;
  assign digit_load = load | reload;

  assign ld_mt = load ? cl_mt : pre_mt;
  assign ld_mo = load ? cl_mo : pre_mo;
  assign ld_st = load ? cl_st : pre_st;
  assign ld_so = load ? cl_so : pre_so;

  bcd_down_digit #(.MAX(9)) u_sec_ones (
    .clk(clk), .reset(reset), .dec_en(tick), .borrow_in(1'b1),
    .load(digit_load), .load_val(ld_so), .digit(d0), .borrow_out(b_so)
  );

  bcd_down_digit #(.MAX(5)) u_sec_tens (
    .clk(clk), .reset(reset), .dec_en(tick), .borrow_in(b_so),
    .load(digit_load), .load_val(ld_st), .digit(d1), .borrow_out(b_st)
  );

  bcd_down_digit #(.MAX(9)) u_min_ones (
    .clk(clk), .reset(reset), .dec_en(tick), .borrow_in(b_st),
    .load(digit_load), .load_val(ld_mo), .digit(d2), .borrow_out(b_mo)
  );

  bcd_down_digit #(.MAX(9)) u_min_tens (
    .clk(clk), .reset(reset), .dec_en(tick), .borrow_in(b_mo),
    .load(digit_load), .load_val(ld_mt), .digit(d3), .borrow_out(b_mt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A borrow out of the minute tens would mean wrapping past 00:00; treat it as expiry.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (!stop && start && !count_zero) state_next = RUN;
        end
        RUN: begin
          if ((reach_zero && !auto_reload) || b_mt) state_next = EXPIRED;
          else if (stop)                            state_next = PAUSE;
        end
        EXPIRED: state_next = EXPIRED;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (load) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_mt <= 4'd0;
      pre_mo <= 4'd0;
      pre_st <= 4'd0;
      pre_so <= 4'd0;
      err    <= 1'b0;
    end else if (load) begin
      pre_mt <= cl_mt;
      pre_mo <= cl_mo;
      pre_st <= cl_st;
      pre_so <= cl_so;
      err    <= clamped;
    end
  end

  always_comb begin
    alarm_cnt_next = alarm_cnt;
    if (load) begin
      alarm_cnt_next = '0;
    end else if (reach_zero) begin
      alarm_cnt_next = ALARM_LOAD;
    end else if (alarm_cnt != '0) begin
      alarm_cnt_next = alarm_cnt - AW'(1);
    end
  end

  // alarm is registered from the next count so it rises in the same cycle as done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_cnt <= '0;
      alarm     <= 1'b0;
      done      <= 1'b0;
    end else begin
      alarm_cnt <= alarm_cnt_next;
      alarm     <= (alarm_cnt_next != '0);
      done      <= reach_zero;
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer_p.sv
// Self-checking bench for countdown_timer_p with TICK_DIV=4, ALARM_CYCLES=3;
// expected digit changes and their cycle offsets are queued and popped as they appear.
module tb_countdown_timer_p;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] m_t = 4'd0, m_o = 4'd0, s_t = 4'd0, s_o = 4'd0;
  logic [3:0] d3, d2, d1, d0;
  logic       running, expired, done, alarm, err;
  logic [15:0] cur;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  assign cur = {d3, d2, d1, d0};

  always #5 clk = ~clk;

  countdown_timer_p #(.TICK_DIV(4), .ALARM_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop),
    .auto_reload(auto_reload), .m_t(m_t), .m_o(m_o), .s_t(s_t), .s_o(s_o),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0), .running(running), .expired(expired),
    .done(done), .alarm(alarm), .err(err)
  );

  task automatic do_load(input logic [3:0] mt, input logic [3:0] mo,
                         input logic [3:0] st, input logic [3:0] so);
    @(negedge clk);
    m_t = mt; m_o = mo; s_t = st; s_o = so;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cur, running, expired, done, alarm, err} !== 21'h0) begin
      errors++;
      $display("[TB] FAIL reset_values got %h expected 0", {cur, running, expired, done, alarm, err});
    end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    exp_t        e;
    logic [15:0] prev;
    int          done_seen = 0;
    int          alarm_seen = 0;
    do_load(4'd0, 4'd0, 4'd0, 4'd3);
    sb.push_back('{4, 16'h0002});
    sb.push_back('{8, 16'h0001});
    sb.push_back('{12, 16'h0000});
    @(negedge clk);
    start = 1'b1;
    prev = cur;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL basic_extra_change got %h expected no change", cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e.val || (i - 1) != e.cyc) begin
            errors++;
            $display("[TB] FAIL basic_digits got %h at %0d expected %h at %0d", cur, i - 1, e.val, e.cyc);
          end
        end
        prev = cur;
      end
      if (done === 1'b1) begin
        done_seen++;
        checks++;
        if ((i - 1) != 12) begin
          errors++;
          $display("[TB] FAIL basic_done_cycle got %0d expected 12", i - 1);
        end
      end
      if (alarm === 1'b1) alarm_seen++;
    end
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("[TB] FAIL basic_done_count got %0d expected 1", done_seen);
    end
    checks++;
    if (alarm_seen != 3) begin
      errors++;
      $display("[TB] FAIL basic_alarm_len got %0d expected 3", alarm_seen);
    end
    checks++;
    if (expired !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_expired got %b%b expected 10", expired, running);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_missing got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_borrow;
    exp_t        e;
    logic [15:0] prev;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        sb.push_back('{4, 16'h0959});
      end else begin
        do_load(4'd0, 4'd1, 4'd0, 4'd0);
        sb.push_back('{4, 16'h0059});
      end
      @(negedge clk);
      start = 1'b1;
      prev = cur;
      for (int i = 1; i <= 6; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (cur !== prev) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL borrow_extra_change got %h expected no change", cur);
          end else begin
            e = sb.pop_front();
            if (cur !== e.val || (i - 1) != e.cyc) begin
              errors++;
              $display("[TB] FAIL borrow_digits got %h at %0d expected %h at %0d", cur, i - 1, e.val, e.cyc);
            end
          end
          prev = cur;
        end
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("[TB] FAIL borrow_missing got %0d pending expected 0", sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_auto_reload;
    exp_t        e;
    logic [15:0] prev;
    int          done_seen = 0;
    auto_reload = 1'b1;
    do_load(4'd0, 4'd0, 4'd0, 4'd2);
    sb.push_back('{4, 16'h0001});
    sb.push_back('{8, 16'h0002});
    @(negedge clk);
    start = 1'b1;
    prev = cur;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL reload_extra_change got %h expected no change", cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e.val || (i - 1) != e.cyc) begin
            errors++;
            $display("[TB] FAIL reload_digits got %h at %0d expected %h at %0d", cur, i - 1, e.val, e.cyc);
          end
        end
        prev = cur;
      end
      checks++;
      if (running !== 1'b1 || cur === 16'h0000) begin
        errors++;
        $display("[TB] FAIL reload_running got %b/%h expected 1/nonzero", running, cur);
      end
      if (done === 1'b1) begin
        done_seen++;
        checks++;
        if ((i - 1) != 8) begin
          errors++;
          $display("[TB] FAIL reload_done_cycle got %0d expected 8", i - 1);
        end
      end
    end
    checks++;
    if (done_seen != 1 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL reload_done_count got %0d/%0d expected 1/0", done_seen, sb.size());
      sb.delete();
    end
    auto_reload = 1'b0;
  endtask

  task automatic test_pause_resume;
    exp_t        e;
    logic [15:0] prev;
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      start = 1'b0;
      stop = (i == 2);
    end
    stop = 1'b0;
    checks++;
    if (cur !== 16'h0005 || running !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_hold got %h/%b expected 0005/0", cur, running);
    end
    sb.push_back('{2, 16'h0004});
    @(negedge clk);
    start = 1'b1;
    prev = cur;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL resume_extra_change got %h expected no change", cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e.val || (i - 1) != e.cyc) begin
            errors++;
            $display("[TB] FAIL resume_digits got %h at %0d expected %h at %0d", cur, i - 1, e.val, e.cyc);
          end
        end
        prev = cur;
      end
    end
    checks++;
    if (sb.size() != 0 || running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resume_state got %0d/%b expected 0/1", sb.size(), running);
      sb.delete();
    end
    // drive to expiry, then try to restart
    do_load(4'd0, 4'd0, 4'd0, 4'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (running !== 1'b0 || expired !== 1'b1 || cur !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL expired_start got %b%b/%h expected 01/0000", running, expired, cur);
    end
  endtask

  task automatic test_clamp_priority;
    do_load(4'd1, 4'd12, 4'd7, 4'd3);
    checks++;
    if (cur !== 16'h1953 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clamp_load got %h/%b expected 1953/1", cur, err);
    end
    do_load(4'd2, 4'd3, 4'd4, 4'd5);
    checks++;
    if (cur !== 16'h2345 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clamp_clear got %h/%b expected 2345/0", cur, err);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    m_t = 4'd0; m_o = 4'd0; s_t = 4'd4; s_o = 4'd2;
    load = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    load = 1'b0;
    stop = 1'b0;
    checks++;
    if (running !== 1'b0 || cur !== 16'h0042) begin
      errors++;
      $display("[TB] FAIL load_stop got %b/%h expected 0/0042", running, cur);
    end
    m_t = 4'd0; m_o = 4'd0; s_t = 4'd3; s_o = 4'd0;
    load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (running !== 1'b0 || cur !== 16'h0030) begin
      errors++;
      $display("[TB] FAIL load_start got %b/%h expected 0/0030", running, cur);
    end
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (running !== 1'b0 || cur !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL start_zero got %b/%h expected 0/0000", running, cur);
    end
  endtask

  task automatic test_reset_mid_run;
    do_load(4'd0, 4'd5, 4'd1, 4'd7);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (running !== 1'b1 || cur !== 16'h0517) begin
      errors++;
      $display("[TB] FAIL midrun_pre got %b/%h expected 1/0517", running, cur);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({cur, running, expired, done, alarm, err} !== 21'h0) begin
      errors++;
      $display("[TB] FAIL midrun_async got %h expected 0", {cur, running, expired, done, alarm, err});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (running !== 1'b0 || cur !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midrun_restart got %b/%h expected 0/0000", running, cur);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_auto_reload();
    test_pause_resume();
    test_clamp_priority();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
